// File: rtl/rr_grant_arbiter_if.sv
// Requester/consumer bundle for the round-robin grant arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface rr_grant_arbiter_if #(
    parameter int NR_REQ     = 4,
    parameter int DATA_WIDTH = 8
);
    localparam int IDX_WIDTH = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]            req_valid;
    logic [NR_REQ-1:0]            req_ready;
    logic [NR_REQ*DATA_WIDTH-1:0] req_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [NR_REQ-1:0]            grant_onehot;
    logic [IDX_WIDTH-1:0]         grant_idx;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, grant_onehot, grant_idx
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, grant_onehot, grant_idx
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held from grant to handshake.
// Request seen in IDLE -> out_valid next cycle; out_ready low stalls in BUSY with the grant frozen.
module rr_grant_arbiter #(
    parameter int NR_REQ     = 4,
    parameter int DATA_WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int IDX_WIDTH = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_WIDTH-1:0]  r_ptr;
    logic [IDX_WIDTH-1:0]  w_ptr_nxt;
    logic [IDX_WIDTH-1:0]  r_grant_idx;
    logic [IDX_WIDTH-1:0]  w_grant_idx_nxt;
    logic [NR_REQ-1:0]     r_grant_onehot;
    logic [NR_REQ-1:0]     w_grant_onehot_nxt;
    logic [IDX_WIDTH-1:0]  w_winner;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_out_data;

    // Scan ptr, ptr+1, ... with wrap; the first valid requester wins.
    always_comb begin
        int                   j;
        logic [IDX_WIDTH-1:0] idx;
        j        = 0;
        idx      = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NR_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NR_REQ) begin
                j = j - NR_REQ;
            end
            idx = IDX_WIDTH'(j);
            if (!w_found && bus.req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_ptr_nxt          = r_ptr;
        w_grant_idx_nxt    = r_grant_idx;
        w_grant_onehot_nxt = r_grant_onehot;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_onehot_nxt = NR_REQ'(1) << w_winner;
                    w_grant_idx_nxt    = w_winner;
                    w_state_nxt        = BUSY;
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    w_ptr_nxt          = (r_grant_idx == IDX_WIDTH'(NR_REQ - 1)) ?
                                         '0 : r_grant_idx + IDX_WIDTH'(1);
                    w_grant_onehot_nxt = '0;
                    w_grant_idx_nxt    = '0;
                    w_state_nxt        = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_ptr          <= '0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ptr          <= w_ptr_nxt;
            r_grant_idx    <= w_grant_idx_nxt;
            r_grant_onehot <= w_grant_onehot_nxt;
        end
    end

    // AND-OR select keyed by the registered grant, so the mux select never glitches.
    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            w_out_data = w_out_data |
                (bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_grant_onehot[i]}});
        end
    end

    assign bus.out_valid    = (r_state == BUSY);
    assign bus.out_data     = w_out_data;
    assign bus.grant_onehot = r_grant_onehot;
    assign bus.grant_idx    = r_grant_idx;
    assign bus.req_ready    = r_grant_onehot & {NR_REQ{bus.out_ready}};

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_grant_onehot));
    a_grant_iff_busy: assert property (@(posedge clk) disable iff (!rst_n)
        ((r_grant_onehot != '0) == (r_state == BUSY)));
    // Granted requester dropping valid before its ready is a protocol violation.
    a_granted_holds_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == BUSY) |-> |(bus.req_valid & r_grant_onehot));
endmodule
